// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one adder between NUM_REQ valid/ready requesters.
// The winner's {cout,sum} is captured in a single-entry response buffer tagged with its ID.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  localparam int unsigned NUM_U = NUM_REQ;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_can_accept;
  logic             w_found;
  logic             w_xfer;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH:0]   w_result;

  // (base + off) mod NUM_REQ; base < NUM_REQ and off <= NUM_REQ, so one subtract suffices.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_U) s = s - NUM_U;
    return s[ID_W-1:0];
  endfunction

  assign w_can_accept = (r_state == S_EMPTY) || rsp_ready;
  assign w_xfer       = w_found;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    if (w_can_accept) begin
      for (int unsigned k = 0; k < NUM_U; k++) begin
        if (!w_found && req_valid[wrap_idx(r_ptr, k)]) begin
          w_found   = 1'b1;
          w_gnt_idx = wrap_idx(r_ptr, k);
        end
      end
    end
  end

  // Operand mux feeding the single shared adder.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_cin = req_cin[i];
      end
    end
  end

  assign w_result = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_xfer) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_xfer)         w_state_nxt = S_FULL;
        else if (rsp_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // NOTE: payload registers are reset too, because the reset value of rsp_* is observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_xfer) begin
      r_sum  <= w_result[WIDTH-1:0];
      r_cout <= w_result[WIDTH];
      r_id   <= w_gnt_idx;
      r_ptr  <= wrap_idx(w_gnt_idx, 1);
    end
  end

  // req_ready is gated by rst_n so it drops immediately, not at the next edge.
  always_comb begin
    req_ready = '0;
    if (rst_n && w_found) req_ready[w_gnt_idx] = 1'b1;
    rsp_valid = (r_state == S_FULL);
    rsp_id    = r_id;
    rsp_sum   = r_sum;
    rsp_cout  = r_cout;
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized bench for adder_share_arbiter: a queue-free behavioural model checked every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_adder_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  int total = 0;
  int bad   = 0;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: buffer contents and round-robin pointer as plain integers.
  bit          m_valid;
  int unsigned m_id;
  int unsigned m_sum;
  int unsigned m_cout;
  int unsigned m_ptr;

  always @(negedge clk) begin
    int g;
    longint s;
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_sum = 0; m_cout = 0; m_ptr = 0;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
      check("rst_rsp_id",    32'(rsp_id),    32'd0);
    end else begin
      check("mdl_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("mdl_rsp_id",    32'(rsp_id),    m_id);
      check("mdl_rsp_sum",   32'(rsp_sum),   m_sum);
      check("mdl_rsp_cout",  32'(rsp_cout),  m_cout);
      g = -1;
      if (!m_valid || rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[(int'(m_ptr) + k) % N]) begin
            g = (int'(m_ptr) + k) % N;
            break;
          end
        end
      end
      check("mdl_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      if (g >= 0) begin
        s = longint'(req_a[g*W +: W]) + longint'(req_b[g*W +: W]) + longint'(req_cin[g]);
        m_sum   = int'(s % (64'd1 << W));
        m_cout  = int'(s >> W);
        m_valid = 1;
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic [IW-1:0] held_id;
    int rr_exp [6];
    rr_exp = '{0, 1, 2, 3, 0, 1};

    rst_n = 0; rsp_ready = 0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    repeat (3) tick();
    rst_n = 1;

    // Single request from requester 0.
    set_op(0, 16'h1234, 16'h0001, 1'b1);
    req_valid = 4'b0001; rsp_ready = 1;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_id",    32'(rsp_id),    32'd0);
    check("single_sum",   32'(rsp_sum),   32'h1236);
    check("single_cout",  32'(rsp_cout),  32'd0);

    // Pointer is now 1: 1001 must grant 3, then 0.
    set_op(0, 16'h0010, 16'h0020, 1'b0);
    set_op(3, 16'h0100, 16'h0200, 1'b1);
    req_valid = 4'b1001;
    #1 check("skip_ready3", 32'(req_ready), 32'h8);
    tick();
    check("skip_id3",  32'(rsp_id),  32'd3);
    check("skip_sum3", 32'(rsp_sum), 32'h0301);
    check("skip_ready0", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    check("skip_id0",  32'(rsp_id),  32'd0);
    check("skip_sum0", 32'(rsp_sum), 32'h0030);

    // Overflow wrap on requester 2.
    set_op(2, 16'hFFFF, 16'h0001, 1'b0);
    req_valid = 4'b0100;
    tick(); req_valid = '0;
    check("ovf1_id",   32'(rsp_id),   32'd2);
    check("ovf1_sum",  32'(rsp_sum),  32'h0000);
    check("ovf1_cout", 32'(rsp_cout), 32'd1);
    set_op(2, 16'hFFFF, 16'hFFFF, 1'b1);
    req_valid = 4'b0100;
    tick(); req_valid = '0;
    check("ovf2_sum",  32'(rsp_sum),  32'hFFFF);
    check("ovf2_cout", 32'(rsp_cout), 32'd1);

    // Bring pointer back to 0 via requester 3, then round-robin with all valid.
    req_valid = 4'b1000;
    tick();
    for (int i = 0; i < N; i++) set_op(i, W'(i * 16'h1111), W'(16'h0001), 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) rsp_ready = 0;
      check("rr_id", 32'(rsp_id), 32'(rr_exp[k]));
      check("rr_valid", 32'(rsp_valid), 32'd1);
    end

    // Backpressure: three stalled cycles, then drain plus refill in one cycle.
    held_sum = rsp_sum; held_id = rsp_id;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_sum", 32'(rsp_sum), 32'(held_sum));
      check("bp_id",  32'(rsp_id),  32'(held_id));
      tick();
    end
    rsp_ready = 1;
    #1 check("bp_release_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    check("bp_release_id",    32'(rsp_id),    32'd2);

    // Randomized traffic, including boundary operands.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       set_op(i, 16'hFFFF, 16'hFFFF, 1'($urandom));
          1:       set_op(i, 16'hFFFF, 16'h0001, 1'b0);
          2:       set_op(i, 16'h0000, 16'h0000, 1'($urandom));
          default: set_op(i, W'($urandom), W'($urandom), 1'($urandom));
        endcase
      end
      tick();
    end

    // Asynchronous reset with a pending response.
    rsp_ready = 1; req_valid = 4'b0001;
    set_op(0, 16'h00AA, 16'h0055, 1'b0);
    tick();
    rsp_ready = 0; req_valid = 4'b1111;
    #1 check("arst_pre_valid", 32'(rsp_valid), 32'd1);
    rst_n = 0;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_sum",   32'(rsp_sum),   32'd0);
    check("arst_id",    32'(rsp_id),    32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1; rsp_ready = 1; req_valid = 4'b1110;
    #1 check("arst_first_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    check("arst_first_id", 32'(rsp_id), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
